// File: rtl/hcsr04_echo_emulator_pkg.sv
// Shared definitions for the HC-SR04 echo emulator: state codes, default timing
// constants and datapath widths.
package hcsr04_echo_emulator_pkg;

   localparam int TRIG_MIN_CYCLES_DEF    = 500;
   localparam int BURST_DELAY_CYCLES_DEF = 10_000;
   localparam int CYCLES_PER_CM_DEF      = 2_941;
   localparam int MAX_CM_DEF             = 400;
   localparam int NO_ECHO_CYCLES_DEF     = 1_900_000;
   localparam int HOLDOFF_CYCLES_DEF     = 500_000;

   localparam int CNT_W   = 21;
   localparam int DIST_W  = 9;
   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 4'h0,
      ST_TRIG    = 4'h1,
      ST_BURST   = 4'h2,
      ST_ECHO    = 4'h3,
      ST_HOLDOFF = 4'h4
   } state_t;

endpackage

// File: rtl/hcsr04_echo_emulator_if.sv
// Trigger/echo bundle between a measuring interface (master) and the emulated
// sensor (slave), plus the distance setting and debug state.
interface hcsr04_echo_emulator_if;
   import hcsr04_echo_emulator_pkg::*;

   logic               trigger;
   logic [DIST_W-1:0]  distance_cm;
   logic               object_present;
   logic               echo;
   logic               busy;
   logic [STATE_W-1:0] db_estado;

   modport master (
      output trigger, distance_cm, object_present,
      input  echo, busy, db_estado
   );

   modport slave (
      input  trigger, distance_cm, object_present,
      output echo, busy, db_estado
   );

endinterface

// File: rtl/hcsr04_width_calc.sv
// Registered echo width: max(d,1)*CYCLES_PER_CM, or NO_ECHO_CYCLES when there is
// no object or the distance is beyond MAX_CM. One cycle of latency.
module hcsr04_width_calc
   import hcsr04_echo_emulator_pkg::*;
#(
   parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
   parameter int MAX_CM         = MAX_CM_DEF,
   parameter int NO_ECHO_CYCLES = NO_ECHO_CYCLES_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DIST_W-1:0] i_distance_cm,
   input  logic              i_object_present,
   output logic [CNT_W-1:0]  o_width
);

   logic [DIST_W-1:0] w_dist_eff;
   logic [CNT_W-1:0]  w_width;
   logic [CNT_W-1:0]  r_width;

   always_comb begin
      w_dist_eff = (i_distance_cm == '0) ? DIST_W'(1) : i_distance_cm;
      if (!i_object_present || (int'(i_distance_cm) > MAX_CM))
         w_width = CNT_W'(NO_ECHO_CYCLES);
      else
         w_width = CNT_W'(w_dist_eff) * CNT_W'(CYCLES_PER_CM);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_width <= '0;
      else
         r_width <= w_width;
   end

   assign o_width = r_width;

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: qualifies a trigger pulse, waits the burst delay, then drives
// an echo whose width encodes the latched distance, followed by a holdoff.
module hcsr04_echo_emulator
   import hcsr04_echo_emulator_pkg::*;
#(
   parameter int TRIG_MIN_CYCLES    = TRIG_MIN_CYCLES_DEF,
   parameter int BURST_DELAY_CYCLES = BURST_DELAY_CYCLES_DEF,
   parameter int CYCLES_PER_CM      = CYCLES_PER_CM_DEF,
   parameter int MAX_CM             = MAX_CM_DEF,
   parameter int NO_ECHO_CYCLES     = NO_ECHO_CYCLES_DEF,
   parameter int HOLDOFF_CYCLES     = HOLDOFF_CYCLES_DEF
) (
   input logic                   clock,
   input logic                   reset,
   hcsr04_echo_emulator_if.slave io_bus
);

   logic              r_sync1;
   logic              r_trig_s;
   logic              r_armed;
   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_next;
   logic [DIST_W-1:0] r_dist;
   logic              r_obj;
   logic              r_echo;
   logic              r_busy;
   logic              w_latch;
   logic              w_disarm;
   logic [CNT_W-1:0]  w_width;

   hcsr04_width_calc #(
      .CYCLES_PER_CM  (CYCLES_PER_CM),
      .MAX_CM         (MAX_CM),
      .NO_ECHO_CYCLES (NO_ECHO_CYCLES)
   ) u_width_calc (
      .clock            (clock),
      .reset            (reset),
      .i_distance_cm    (r_dist),
      .i_object_present (r_obj),
      .o_width          (w_width)
   );

   // Every state loads (duration - 1) on entry and leaves when the count reaches 0.
   // In TRIG the count only moves while trig_s is high, so reaching 0 means the
   // pulse was at least TRIG_MIN_CYCLES wide.
   always_comb begin
      w_state_next = r_state;
      w_count_next = (r_count != '0) ? r_count - CNT_W'(1) : '0;
      w_latch      = 1'b0;
      w_disarm     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_armed && r_trig_s) begin
               w_state_next = ST_TRIG;
               w_count_next = CNT_W'(TRIG_MIN_CYCLES - 1);
            end
         end
         ST_TRIG: begin
            if (!r_trig_s) begin
               if (r_count == '0) begin
                  w_state_next = ST_BURST;
                  w_count_next = CNT_W'(BURST_DELAY_CYCLES - 1);
                  w_latch      = 1'b1;
               end else begin
                  w_state_next = ST_IDLE;
                  w_count_next = '0;
               end
            end
         end
         ST_BURST: begin
            if (r_count == '0) begin
               w_state_next = ST_ECHO;
               w_count_next = w_width - CNT_W'(1);
            end
         end
         ST_ECHO: begin
            if (r_count == '0) begin
               w_state_next = ST_HOLDOFF;
               w_count_next = CNT_W'(HOLDOFF_CYCLES - 1);
            end
         end
         ST_HOLDOFF: begin
            if (r_count == '0) begin
               w_state_next = ST_IDLE;
               w_disarm     = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_trig_s <= 1'b0;
         r_armed  <= 1'b0;
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_dist   <= '0;
         r_obj    <= 1'b0;
         r_echo   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_sync1  <= io_bus.trigger;
         r_trig_s <= r_sync1;
         // A trigger still high when holdoff ends must fall before it can re-arm.
         if (!r_trig_s)
            r_armed <= 1'b1;
         else if (w_disarm)
            r_armed <= 1'b0;
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_latch) begin
            r_dist <= io_bus.distance_cm;
            r_obj  <= io_bus.object_present;
         end
         r_echo <= (w_state_next == ST_ECHO);
         r_busy <= (w_state_next == ST_BURST) || (w_state_next == ST_ECHO) ||
                   (w_state_next == ST_HOLDOFF);
      end
   end

   assign io_bus.echo      = r_echo;
   assign io_bus.busy      = r_busy;
   assign io_bus.db_estado = r_state;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Directed and randomized checks of the echo emulator against a protocol-level
// model of expected echo latency and width.
module tb_hcsr04_echo_emulator;

   localparam int T_TRIG   = 5;
   localparam int T_BURST  = 10;
   localparam int T_CPM    = 3;
   localparam int T_MAX    = 20;
   localparam int T_NOECHO = 100;
   localparam int T_HOLD   = 20;
   // pin fall -> echo rise: 2 synchroniser cycles + burst delay + 1
   localparam int LAT      = T_BURST + 1 + 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   hcsr04_echo_emulator_if bus_if ();

   hcsr04_echo_emulator #(
      .TRIG_MIN_CYCLES    (T_TRIG),
      .BURST_DELAY_CYCLES (T_BURST),
      .CYCLES_PER_CM      (T_CPM),
      .MAX_CM             (T_MAX),
      .NO_ECHO_CYCLES     (T_NOECHO),
      .HOLDOFF_CYCLES     (T_HOLD)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .io_bus (bus_if)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   bit prev_echo = 1'b0;
   int rise_cyc  = 0;
   int last_width = 0;
   int rises     = 0;
   int falls     = 0;
   int busy_drop = 0;
   int busy_seen = 0;

   always @(negedge clock) begin
      if (bus_if.echo && !prev_echo) begin
         rise_cyc = cyc;
         rises++;
      end
      if (!bus_if.echo && prev_echo) begin
         last_width = cyc - rise_cyc;
         falls++;
      end
      if (bus_if.echo && !bus_if.busy) busy_drop++;
      if (bus_if.busy) busy_seen++;
      prev_echo = bus_if.echo;
   end

   int vectors     = 0;
   int miscompares = 0;
   int fall_cyc    = 0;

   function automatic int ref_width(int d, bit obj);
      if (!obj || d > T_MAX) return T_NOECHO;
      return ((d < 1) ? 1 : d) * T_CPM;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_trigger(input int len);
      @(posedge clock);
      #1 bus_if.trigger = 1'b1;
      repeat (len) @(posedge clock);
      #1 bus_if.trigger = 1'b0;
      fall_cyc = cyc;
   endtask

   task automatic wait_rise(input int r0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clock);
         #1;
         if (rises > r0) ok = 1'b1;
      end
   endtask

   task automatic wait_fall(input int f0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clock);
         #1;
         if (falls > f0) ok = 1'b1;
      end
   endtask

   task automatic measure(input string tag, input int d, input bit obj, input int len);
      int f0;
      int bd0;
      bit ok;
      bus_if.distance_cm    = 9'(d);
      bus_if.object_present = obj;
      f0  = falls;
      bd0 = busy_drop;
      pulse_trigger(len);
      wait_fall(f0, ok);
      check({tag, "_done"}, int'(ok), 1);
      if (ok) begin
         check({tag, "_latency"}, rise_cyc - fall_cyc, LAT);
         check({tag, "_width"}, last_width, ref_width(d, obj));
         check({tag, "_busy_in_echo"}, busy_drop - bd0, 0);
      end
      $display("txn %s: d=%0d obj=%0d trig=%0d width=%0d expect=%0d",
               tag, d, obj, len, last_width, ref_width(d, obj));
      repeat (T_HOLD + 5) @(negedge clock);
      #1;
      check({tag, "_idle_busy"}, int'(bus_if.busy), 0);
   endtask

   initial begin
      int  f0, r0, r1, b0, bd0, d, len;
      bit  ok, obj;

      bus_if.trigger        = 1'b0;
      bus_if.distance_cm    = '0;
      bus_if.object_present = 1'b1;

      // reset state
      repeat (3) @(negedge clock);
      check("rst_echo", int'(bus_if.echo), 0);
      check("rst_busy", int'(bus_if.busy), 0);
      check("rst_state", int'(bus_if.db_estado), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);

      // basic measurement with holdoff boundary
      bus_if.distance_cm = 9'd7;
      f0  = falls;
      bd0 = busy_drop;
      pulse_trigger(6);
      repeat (4) @(negedge clock);
      #1;
      check("t1_burst_busy", int'(bus_if.busy), 1);
      check("t1_burst_state", int'(bus_if.db_estado), 2);
      wait_fall(f0, ok);
      check("t1_done", int'(ok), 1);
      check("t1_latency", rise_cyc - fall_cyc, LAT);
      check("t1_width", last_width, ref_width(7, 1'b1));
      check("t1_busy_in_echo", busy_drop - bd0, 0);
      repeat (T_HOLD - 1) @(negedge clock);
      #1;
      check("t1_holdoff_busy", int'(bus_if.busy), 1);
      check("t1_holdoff_state", int'(bus_if.db_estado), 4);
      @(negedge clock);
      #1;
      check("t1_end_busy", int'(bus_if.busy), 0);
      check("t1_end_state", int'(bus_if.db_estado), 0);
      $display("txn t1: d=7 width=%0d", last_width);
      repeat (3) @(negedge clock);

      // runt pulse
      r0 = rises;
      b0 = busy_seen;
      pulse_trigger(3);
      repeat (30) @(negedge clock);
      #1;
      check("t2_runt_echo", rises - r0, 0);
      check("t2_runt_busy", busy_seen - b0, 0);
      check("t2_runt_state", int'(bus_if.db_estado), 0);
      $display("txn t2: runt 3 cycles");

      // width rule corners and minimum accepted trigger
      measure("t3_far", 25, 1'b1, 6);
      measure("t3_noobj", 7, 1'b0, 6);
      measure("t3_zero", 0, 1'b1, 6);
      measure("t3_max", 20, 1'b1, 6);
      measure("t3_over", 21, 1'b1, 6);
      measure("t3_trigmin", 9, 1'b1, T_TRIG);

      // distance change during echo, trigger during holdoff
      bus_if.distance_cm    = 9'd7;
      bus_if.object_present = 1'b1;
      f0 = falls;
      r0 = rises;
      pulse_trigger(6);
      wait_rise(r0, ok);
      check("t4_rise", int'(ok), 1);
      bus_if.distance_cm = 9'd15;
      wait_fall(f0, ok);
      check("t4_done", int'(ok), 1);
      check("t4_width", last_width, ref_width(7, 1'b1));
      r1 = rises;
      pulse_trigger(6);
      repeat (40) @(negedge clock);
      #1;
      check("t4_holdoff_ignored", rises - r1, 0);
      $display("txn t4: first width=%0d, holdoff trigger ignored", last_width);
      measure("t4_after_busy", 15, 1'b1, 6);

      // asynchronous reset mid-echo
      bus_if.distance_cm = 9'd7;
      r0 = rises;
      pulse_trigger(6);
      wait_rise(r0, ok);
      check("t5_rise", int'(ok), 1);
      repeat (5) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("t5_async_echo", int'(bus_if.echo), 0);
      check("t5_async_busy", int'(bus_if.busy), 0);
      check("t5_async_state", int'(bus_if.db_estado), 0);
      $display("txn t5: reset mid-echo");
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      measure("t5_post_reset", 7, 1'b1, 6);

      // trigger held through holdoff must not re-fire
      bus_if.distance_cm = 9'd7;
      f0 = falls;
      pulse_trigger(6);
      wait_fall(f0, ok);
      check("t6_done", int'(ok), 1);
      @(posedge clock);
      #1 bus_if.trigger = 1'b1;
      r0 = rises;
      repeat (T_HOLD + 20) @(negedge clock);
      #1;
      check("t6_held_no_echo", rises - r0, 0);
      check("t6_held_idle", int'(bus_if.busy), 0);
      @(posedge clock);
      #1 bus_if.trigger = 1'b0;
      repeat (30) @(negedge clock);
      #1;
      check("t6_fall_no_echo", rises - r0, 0);
      $display("txn t6: held trigger ignored");
      measure("t6_rearm", 7, 1'b1, 6);

      // randomized measurements
      for (int i = 0; i < 10; i++) begin
         d   = int'($urandom_range(0, 26));
         obj = ($urandom_range(0, 3) != 0);
         len = int'($urandom_range(T_TRIG, T_TRIG + 4));
         measure($sformatf("rnd%0d", i), d, obj, len);
      end

      // randomized runts
      for (int i = 0; i < 4; i++) begin
         len = int'($urandom_range(1, T_TRIG - 1));
         r0 = rises;
         b0 = busy_seen;
         pulse_trigger(len);
         repeat (30) @(negedge clock);
         #1;
         check($sformatf("rnd_runt%0d_echo", i), rises - r0, 0);
         check($sformatf("rnd_runt%0d_busy", i), busy_seen - b0, 0);
         $display("txn rnd_runt%0d: len=%0d", i, len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
